ipml_prefetch_rd_stage_v2: RTL and testbench

- Parametrised first-word-fall-through read stage placed between an SDPRAM-based FIFO core (pointer/flag controller plus RAM) and a valid/ready consumer.
- Generalises the fixed 2-deep register prefetch: the RAM read latency is configurable (1..3), the prefetch depth is configurable, and reads are issued on credits that count in-flight reads.
- Adds a synchronous flush, a buffer fill-level output and an almost-empty indication.

---
 rtl/ipml_prefetch_rd_stage_v2.sv | 116 +++++++++++
 tb/tb_ipml_prefetch_rd_stage_v2.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ipml_prefetch_rd_stage_v2.sv
// First-word-fall-through read stage between an SDPRAM FIFO core and a
// valid/ready consumer. RAM reads are issued against a credit that counts
// both buffered words and reads still travelling through the RAM pipeline,
// so a returning word always has a free slot and the RAM is never stalled.
`timescale 1ns/1ps
module ipml_prefetch_rd_stage_v2 #(
  parameter  int c_DATA_WIDTH     = 32,
  parameter  int c_RAM_RD_LATENCY = 1,
  parameter  int c_PREFETCH_DEPTH = 2,
  parameter  int c_AEMPTY_THRESH  = 1,
  localparam int c_LVL_WIDTH      = $clog2(c_PREFETCH_DEPTH + 1)
) (
  input  logic                    rd_clk,
  input  logic                    rd_rst,
  input  logic                    flush,
  input  logic                    ram_empty,
  output logic                    ram_rd_en,
  input  logic [c_DATA_WIDTH-1:0] ram_rd_data,
  output logic [c_DATA_WIDTH-1:0] rd_data,
  output logic                    rd_vld,
  input  logic                    rd_en,
  output logic [c_LVL_WIDTH-1:0]  pf_level,
  output logic                    rd_aempty
);

  localparam int L  = c_RAM_RD_LATENCY;
  localparam int D  = c_PREFETCH_DEPTH;
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  // Wide enough to hold buffered + in-flight words (at most D + L).
  localparam int CW = $clog2(D + L + 1);

  logic [c_DATA_WIDTH-1:0] buf_q [D];
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [c_LVL_WIDTH-1:0]  count_q, count_d;
  logic [L-1:0]            infl_q, infl_d;
  logic                    aempty_q;
  logic [CW-1:0]           infl_cnt;
  logic                    pop, arrive, credit_ok;

  // Pointers wrap at D explicitly so non-power-of-2 depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + PW'(1);
  endfunction

  assign rd_vld    = (count_q != '0);
  assign rd_data   = buf_q[rd_ptr_q];
  assign pf_level  = count_q;
  assign rd_aempty = aempty_q;
  assign pop       = rd_vld & rd_en;
  // Oldest stage of the tracker: its word is on ram_rd_data this cycle.
  assign arrive    = infl_q[L-1];

  // Shift a new issue into the in-flight tracker.
  generate
    if (L == 1) begin : g_lat1
      assign infl_d = ram_rd_en;
    end else begin : g_latn
      assign infl_d = {infl_q[L-2:0], ram_rd_en};
    end
  endgenerate

  // Count in-flight reads, including the one landing this cycle.
  always_comb begin
    infl_cnt = '0;
    for (int k = 0; k < L; k++) infl_cnt = infl_cnt + CW'(infl_q[k]);
  end

  // Issue while buffered + in-flight stays below depth; a pop this cycle
  // frees its slot immediately. pop implies count_q >= 1, so no underflow.
  assign credit_ok = (CW'(count_q) + infl_cnt - CW'(pop)) < CW'(D);
  assign ram_rd_en = ~ram_empty & ~flush & ~rd_rst & credit_ok;

  // Next fill level; flush wins over simultaneous pop/arrival.
  always_comb begin
    count_d = count_q;
    case ({arrive, pop})
      2'b10:   count_d = count_q + c_LVL_WIDTH'(1);
      2'b01:   count_d = count_q - c_LVL_WIDTH'(1);
      default: count_d = count_q;
    endcase
    if (flush) count_d = '0;
  end

  // Pointer, level, tracker and almost-empty state.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      infl_q   <= '0;
      aempty_q <= 1'b1;
    end else begin
      count_q  <= count_d;
      aempty_q <= (int'(count_d) <= c_AEMPTY_THRESH);
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        infl_q   <= '0;
      end else begin
        infl_q <= infl_d;
        if (arrive) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop)    rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

  // Capture returning RAM data; words landing in a flush cycle are dropped.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      for (int k = 0; k < D; k++) buf_q[k] <= '0;
    end else if (arrive && !flush) begin
      buf_q[wr_ptr_q] <= ram_rd_data;
    end
  end

endmodule

// File: tb/tb_ipml_prefetch_rd_stage_v2.sv
// Bench for ipml_prefetch_rd_stage_v2: five instances with different
// latency/depth share the control inputs, each fed by its own RAM model and
// checked every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_ipml_prefetch_rd_stage_v2;

  localparam int N = 5;
  localparam int LAT [N] = '{1, 1, 3, 3, 2};
  localparam int DEP [N] = '{2, 4, 2, 4, 4};
  localparam int THR [N] = '{1, 1, 0, 2, 3};

  logic                  rd_clk, rd_rst, flush, ram_empty, rd_en;
  logic [N-1:0]          ram_rd_en, rd_vld, rd_aempty;
  logic [N-1:0][31:0]    ram_rd_data, rd_data;
  logic [N-1:0][4:0]     pf_level;
  logic [31:0]           dl [N][3];
  int                    src_cnt [N];

  int checks, failures, cyc;

  // Reference model state: buffered words, in-flight words with issue cycle.
  logic [31:0] mbuf [N][$];
  logic [31:0] iw   [N][$];
  int          it   [N][$];
  int          mcnt [N];
  // Measurement counters taken from observed DUT outputs.
  int iss [N], pops [N], fiss [N], fvld [N];
  bit seen_iss [N], seen_vld [N];

  typedef struct {
    int inst;
    int first_vld;  // cycles from first ram_rd_en to rd_vld
    int words16;    // pops in 16 steady-state cycles with rd_en=1
    int bp_lvl;     // issues and pf_level under backpressure from empty
  } vec_t;
  vec_t tbl [N];

  function automatic logic [31:0] word(input int i, input int n);
    return {8'(i), 24'(n)};
  endfunction

  generate
    for (genvar g = 0; g < N; g++) begin : g_dut
      logic [$clog2(DEP[g]+1)-1:0] lvl;
      assign pf_level[g]    = 5'(lvl);
      assign ram_rd_data[g] = dl[g][LAT[g]-1];
      ipml_prefetch_rd_stage_v2 #(
        .c_DATA_WIDTH(32), .c_RAM_RD_LATENCY(LAT[g]),
        .c_PREFETCH_DEPTH(DEP[g]), .c_AEMPTY_THRESH(THR[g])
      ) u_dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .flush(flush),
        .ram_empty(ram_empty), .ram_rd_en(ram_rd_en[g]),
        .ram_rd_data(ram_rd_data[g]), .rd_data(rd_data[g]),
        .rd_vld(rd_vld[g]), .rd_en(rd_en), .pf_level(lvl),
        .rd_aempty(rd_aempty[g])
      );
    end
  endgenerate

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  // RAM model: a read strobe returns the next sequential word L cycles later;
  // idle slots carry a marker value that must never be captured.
  always @(posedge rd_clk) begin
    for (int i = 0; i < N; i++) begin
      dl[i][2] <= dl[i][1];
      dl[i][1] <= dl[i][0];
      dl[i][0] <= ram_rd_en[i] ? word(i, src_cnt[i]) : 32'hBAD0_0000;
      if (ram_rd_en[i]) src_cnt[i] <= src_cnt[i] + 1;
    end
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d got=%0h exp=%0h cyc=%0d", nm, i, act, exp, cyc);
    end
  endtask

  // Compare one instance against the model, then advance the model a cycle.
  task automatic model_step(input int i);
    bit pop, en;
    logic [31:0] w;
    if (rd_rst) begin
      chk("rst_rd_en", i, 32'(ram_rd_en[i]), 0);
      chk("rst_vld",   i, 32'(rd_vld[i]), 0);
      chk("rst_data",  i, rd_data[i], 0);
      chk("rst_lvl",   i, 32'(pf_level[i]), 0);
      chk("rst_aempty",i, 32'(rd_aempty[i]), 1);
      mbuf[i].delete(); iw[i].delete(); it[i].delete();
      seen_iss[i] = 0; seen_vld[i] = 0;
      return;
    end
    pop = (mbuf[i].size() > 0) && rd_en;
    en  = !ram_empty && !flush &&
          (mbuf[i].size() + iw[i].size() - int'(pop) < DEP[i]);
    chk("ram_rd_en", i, 32'(ram_rd_en[i]), 32'(en));
    chk("rd_vld",    i, 32'(rd_vld[i]), 32'(mbuf[i].size() > 0));
    chk("pf_level",  i, 32'(pf_level[i]), 32'(mbuf[i].size()));
    chk("rd_aempty", i, 32'(rd_aempty[i]), 32'(mbuf[i].size() <= THR[i]));
    if (mbuf[i].size() > 0) chk("rd_data", i, rd_data[i], mbuf[i][0]);
    if (ram_rd_en[i]) begin
      iss[i]++;
      if (!seen_iss[i]) begin seen_iss[i] = 1; fiss[i] = cyc; end
    end
    if (rd_vld[i] && !seen_vld[i]) begin seen_vld[i] = 1; fvld[i] = cyc; end
    if (rd_vld[i] && rd_en) pops[i]++;
    if (flush) begin
      mbuf[i].delete(); iw[i].delete(); it[i].delete();
    end else begin
      if (pop) void'(mbuf[i].pop_front());
      if (it[i].size() > 0 && it[i][0] + LAT[i] == cyc) begin
        w = iw[i].pop_front();
        void'(it[i].pop_front());
        mbuf[i].push_back(w);
      end
      if (en) begin
        iw[i].push_back(word(i, mcnt[i]));
        it[i].push_back(cyc);
        mcnt[i]++;
      end
    end
  endtask

  // One clock: check at the falling edge, return just after the rising edge.
  task automatic cycle();
    @(negedge rd_clk);
    for (int i = 0; i < N; i++) model_step(i);
    cyc++;
    @(posedge rd_clk);
    #1;
  endtask

  initial begin
    int p0 [N];
    int i0 [N];
    tbl[0] = '{inst:0, first_vld:2, words16:16, bp_lvl:2};
    tbl[1] = '{inst:1, first_vld:2, words16:16, bp_lvl:4};
    tbl[2] = '{inst:2, first_vld:4, words16:8,  bp_lvl:2};
    tbl[3] = '{inst:3, first_vld:4, words16:16, bp_lvl:4};
    tbl[4] = '{inst:4, first_vld:3, words16:16, bp_lvl:4};
    checks = 0; failures = 0; cyc = 0;

    // Reset with a non-empty FIFO.
    rd_rst = 1'b1; flush = 1'b0; ram_empty = 1'b0; rd_en = 1'b1;
    repeat (3) cycle();
    rd_rst = 1'b0;
    #1;
    chk("first_issue", -1, 32'(ram_rd_en), 32'({N{1'b1}}));

    // Streaming: latency to first word and steady-state throughput.
    repeat (10) cycle();
    for (int i = 0; i < N; i++) p0[i] = pops[i];
    repeat (16) cycle();
    for (int r = 0; r < N; r++) begin
      chk("first_vld_lat", tbl[r].inst, 32'(fvld[tbl[r].inst] - fiss[tbl[r].inst]),
          32'(tbl[r].first_vld));
      chk("words16", tbl[r].inst, 32'(pops[tbl[r].inst] - p0[tbl[r].inst]),
          32'(tbl[r].words16));
    end

    // Backpressure from an empty buffer: exactly depth issues, then stop.
    rd_en = 1'b0;
    for (int i = 0; i < N; i++) i0[i] = iss[i];
    flush = 1'b1; cycle(); flush = 1'b0;
    repeat (20) cycle();
    for (int r = 0; r < N; r++) begin
      chk("bp_issues", tbl[r].inst, 32'(iss[tbl[r].inst] - i0[tbl[r].inst]),
          32'(tbl[r].bp_lvl));
      chk("bp_level", tbl[r].inst, 32'(pf_level[tbl[r].inst]), 32'(tbl[r].bp_lvl));
    end
    rd_en = 1'b1;
    repeat (20) cycle();

    // Flush with two words buffered and two in flight on the L=2, D=4 lane.
    rd_en = 1'b0;
    flush = 1'b1; cycle(); flush = 1'b0;
    repeat (4) cycle();
    chk("pre_flush_lvl", 4, 32'(pf_level[4]), 2);
    chk("pre_flush_vld", 4, 32'(rd_vld[4]), 1);
    flush = 1'b1; cycle(); flush = 1'b0;
    chk("post_flush_vld", 4, 32'(rd_vld[4]), 0);
    chk("post_flush_lvl", 4, 32'(pf_level[4]), 0);
    rd_en = 1'b1;
    repeat (20) cycle();

    // Random empty/ready/flush traffic with a reset in the middle.
    for (int c = 0; c < 400; c++) begin
      ram_empty = ($urandom_range(0, 3) == 0);
      rd_en     = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      rd_rst    = (c == 200 || c == 201);
      cycle();
    end
    rd_rst = 1'b0; flush = 1'b0;
    repeat (5) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
